// File: rtl/uart_word_assembler.sv
// ---------------------------------------------------------------------------
// uart_word_assembler
//
// Packs the UART RX byte stream into 32-bit words for the packet decode FSM.
// The first byte received becomes the MSB of the word. A RESYNC byte sequence
// seen on any byte alignment forces the word boundary back into step.
//
// Optional feature (compile-time macro): UART_WORD_ASM_TIMEOUT_EN
//   When defined, a partial word left idle for TIMEOUT_CYCLES cycles is
//   discarded and o_timeout_pulse fires. When undefined there is no timer,
//   o_timeout_pulse is constant 0 and partial words persist indefinitely.
//
// Ports
//   i_clk             in   1          system clock, all logic on posedge
//   i_reset           in   1          asynchronous, active-high reset
//   i_rx_byte_valid   in   1          1-cycle strobe, i_rx_byte valid
//   i_rx_byte         in   8          received byte
//   o_recv_word_cmd   out  1          1-cycle strobe: new word on o_recv_word_data
//   o_recv_word_data  out  32         assembled word, held until next strobe
//   o_byte_count      out  2          bytes held in the partial word (0..3)
//   o_realign_pulse   out  1          1-cycle strobe: misaligned RESYNC forced a boundary
//   o_timeout_pulse   out  1          1-cycle strobe: partial word discarded on idle timeout
//   o_err_count       out  ERR_CNT_W  saturating count of realign + timeout events
// ---------------------------------------------------------------------------
module uart_word_assembler #(
    parameter logic [31:0] RESYNC_WORD    = 32'h416FDC1E,
`ifdef UART_WORD_ASM_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
`endif
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_byte_valid,
    input  logic [7:0]           i_rx_byte,
    output logic                 o_recv_word_cmd,
    output logic [31:0]          o_recv_word_data,
    output logic [1:0]           o_byte_count,
    output logic                 o_realign_pulse,
    output logic                 o_timeout_pulse,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    logic [31:0] sr;     // last four bytes received, newest in [7:0]
    logic [1:0]  cnt;    // bytes held in the current partial word
    logic [2:0]  fill;   // bytes since last clear, saturating at 4

    logic [31:0] nxt;
    logic        realign;
    logic        emit;
    logic        timeout_fire;

    // NOTE: every signal gets a value on every path of an always_comb,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        nxt     = {sr[23:0], i_rx_byte};
        realign = 1'b0;
        emit    = 1'b0;
        if (i_rx_byte_valid) begin
            // A RESYNC only counts once four real bytes back it (fill+1 >= 4),
            // so reset-cleared zeros in sr can never complete a match.
            realign = (nxt == RESYNC_WORD) && (fill >= 3'd3) && (cnt != 2'd3);
            emit    = (cnt == 2'd3) || realign;
        end
    end

`ifdef UART_WORD_ASM_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer;

    // A byte arriving in the expiry cycle wins, so expiry requires no valid.
    assign timeout_fire = !i_rx_byte_valid && (cnt != 2'd0) && (timer == TIMER_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timer <= '0;
        end else if (i_rx_byte_valid || (cnt == 2'd0) || timeout_fire) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sr               <= '0;
            cnt              <= '0;
            fill             <= '0;
            o_recv_word_cmd  <= 1'b0;
            o_recv_word_data <= '0;
            o_realign_pulse  <= 1'b0;
            o_timeout_pulse  <= 1'b0;
            o_err_count      <= '0;
        end else begin
            o_recv_word_cmd <= 1'b0;
            o_realign_pulse <= 1'b0;
            o_timeout_pulse <= 1'b0;

            if (i_rx_byte_valid) begin
                sr   <= nxt;
                fill <= (fill == 3'd4) ? 3'd4 : fill + 3'd1;
                if (emit) begin
                    cnt              <= 2'd0;
                    o_recv_word_data <= nxt;
                    o_recv_word_cmd  <= 1'b1;
                    o_realign_pulse  <= realign;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end else if (timeout_fire) begin
                cnt             <= 2'd0;
                fill            <= 3'd0;
                o_timeout_pulse <= 1'b1;
            end

            // Realign needs a valid byte and timeout needs none, so the two
            // events never coincide and a single increment suffices.
            if ((realign || timeout_fire) && (o_err_count != {ERR_CNT_W{1'b1}})) begin
                o_err_count <= o_err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign o_byte_count = cnt;

endmodule

// File: tb/tb_uart_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_word_assembler
//
// Self-checking bench for uart_word_assembler. Expected words are pushed to a
// scoreboard queue as bytes are driven; a monitor pops and compares them on
// every o_recv_word_cmd strobe. Inputs change and outputs are sampled on the
// falling clock edge. Define UART_WORD_ASM_TIMEOUT_EN to test the timeout
// build (TIMEOUT_CYCLES = 16).
// ---------------------------------------------------------------------------
module tb_uart_word_assembler;

    localparam int ERR_CNT_W = 8;
`ifdef UART_WORD_ASM_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 16;
`endif

    typedef struct {
        logic [31:0] data;
        logic        realign;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 rx_valid = 1'b0;
    logic [7:0]           rx_byte = 8'h00;
    logic                 word_cmd;
    logic [31:0]          word_data;
    logic [1:0]           byte_count;
    logic                 realign_pulse;
    logic                 timeout_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    int   assertions = 0;
    int   failures   = 0;
    exp_t sb[$];

    uart_word_assembler #(
        .RESYNC_WORD   (32'h416FDC1E),
`ifdef UART_WORD_ASM_TIMEOUT_EN
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
`endif
        .ERR_CNT_W     (ERR_CNT_W)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_rx_byte_valid (rx_valid),
        .i_rx_byte       (rx_byte),
        .o_recv_word_cmd (word_cmd),
        .o_recv_word_data(word_data),
        .o_byte_count    (byte_count),
        .o_realign_pulse (realign_pulse),
        .o_timeout_pulse (timeout_pulse),
        .o_err_count     (err_count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && word_cmd) begin
            assertions++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_word: got %h, none expected", word_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (word_data !== e.data || realign_pulse !== e.realign) begin
                    failures++;
                    $display("FAIL sb_word: got data=%h realign=%b, expected data=%h realign=%b",
                             word_data, realign_pulse, e.data, e.realign);
                end
            end
        end
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Drive one byte for one cycle; starts and ends just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic r);
        exp_t e;
        e.data    = d;
        e.realign = r;
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        assertions++;
        if (word_cmd !== 1'b0 || word_data !== 32'h0 || byte_count !== 2'd0 ||
            realign_pulse !== 1'b0 || timeout_pulse !== 1'b0 || err_count !== '0) begin
            failures++;
            $display("FAIL %s: got cmd=%b data=%h cnt=%0d realign=%b timeout=%b err=%0d, expected all 0",
                     name, word_cmd, word_data, byte_count, realign_pulse, timeout_pulse, err_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    // Scenario 1: four bytes -> one word, strobe the cycle after the 4th byte.
    task automatic test_single_word();
        logic [7:0] bytes [4] = '{8'hD7, 8'h8C, 8'h1B, 8'h74};
        push_exp(32'hD78C1B74, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]);
            assertions++;
            if (word_cmd !== (i == 3) || byte_count !== 2'((i + 1) % 4)) begin
                failures++;
                $display("FAIL single_word_byte%0d: got cmd=%b cnt=%0d, expected cmd=%b cnt=%0d",
                         i, word_cmd, byte_count, (i == 3), (i + 1) % 4);
            end
        end
        @(negedge clk);
        assertions++;
        if (word_cmd !== 1'b0 || word_data !== 32'hD78C1B74) begin
            failures++;
            $display("FAIL single_word_hold: got cmd=%b data=%h, expected cmd=0 data=d78c1b74",
                     word_cmd, word_data);
        end
    endtask

    // Scenario 2: eight bytes back to back -> strobes exactly four cycles apart.
    task automatic test_back_to_back();
        push_exp(32'h01020304, 1'b0);
        push_exp(32'h05060708, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i + 1));
            assertions++;
            if (word_cmd !== ((i % 4) == 3)) begin
                failures++;
                $display("FAIL back_to_back_strobe%0d: got cmd=%b, expected %b",
                         i, word_cmd, ((i % 4) == 3));
            end
        end
    endtask

    // Scenario 3: misaligned RESYNC -> normal word, then realign word next cycle.
    task automatic test_realign();
        logic [7:0] bytes [5] = '{8'hAA, 8'h41, 8'h6F, 8'hDC, 8'h1E};
        apply_reset();
        push_exp(32'hAA416FDC, 1'b0);
        push_exp(32'h416FDC1E, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        assertions++;
        if (word_cmd !== 1'b1 || realign_pulse !== 1'b1 || err_count !== 8'd1 || byte_count !== 2'd0) begin
            failures++;
            $display("FAIL realign_state: got cmd=%b realign=%b err=%0d cnt=%0d, expected 1 1 1 0",
                     word_cmd, realign_pulse, err_count, byte_count);
        end
        @(negedge clk);
        assertions++;
        if (realign_pulse !== 1'b0) begin
            failures++;
            $display("FAIL realign_width: got realign=%b one cycle later, expected 0", realign_pulse);
        end
    endtask

    // Scenario 4: aligned RESYNC is an ordinary word, no error.
    task automatic test_aligned_resync();
        logic [7:0] bytes [4] = '{8'h41, 8'h6F, 8'hDC, 8'h1E};
        logic [ERR_CNT_W-1:0] err_before;
        err_before = err_count;
        push_exp(32'h416FDC1E, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(bytes[i]);
        assertions++;
        if (word_cmd !== 1'b1 || realign_pulse !== 1'b0 || err_count !== err_before) begin
            failures++;
            $display("FAIL aligned_resync: got cmd=%b realign=%b err=%0d, expected 1 0 %0d",
                     word_cmd, realign_pulse, err_count, err_before);
        end
    endtask

    // Scenario 5: idle partial word (timeout build) or persistence (default build).
    task automatic test_timeout();
        int waited;
        bit seen;
        apply_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        waited = 0;
        seen   = 1'b0;
`ifdef UART_WORD_ASM_TIMEOUT_EN
        while (!seen && waited < 4 * TIMEOUT_CYCLES) begin
            @(negedge clk);
            waited++;
            if (timeout_pulse === 1'b1) seen = 1'b1;
        end
        assertions++;
        if (!seen || waited != TIMEOUT_CYCLES || err_count !== 8'd1 || byte_count !== 2'd0) begin
            failures++;
            $display("FAIL timeout_expiry: got seen=%b after %0d cycles err=%0d cnt=%0d, expected 1 after %0d err=1 cnt=0",
                     seen, waited, err_count, byte_count, TIMEOUT_CYCLES);
        end
        @(negedge clk);
        assertions++;
        if (timeout_pulse !== 1'b0) begin
            failures++;
            $display("FAIL timeout_width: got pulse=%b one cycle later, expected 0", timeout_pulse);
        end
        push_exp(32'h33445566, 1'b0);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
`else
        repeat (40) begin
            @(negedge clk);
            waited++;
            if (timeout_pulse !== 1'b0) seen = 1'b1;
        end
        assertions++;
        if (seen || byte_count !== 2'd2 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL no_timeout_persist: got pulse_seen=%b cnt=%0d err=%0d, expected 0 2 0",
                     seen, byte_count, err_count);
        end
        push_exp(32'h11223344, 1'b0);
        send_byte(8'h33);
        send_byte(8'h44);
`endif
        assertions++;
        if (word_cmd !== 1'b1 || byte_count !== 2'd0) begin
            failures++;
            $display("FAIL timeout_next_word: got cmd=%b cnt=%0d, expected 1 0", word_cmd, byte_count);
        end
    endtask

    // Scenario 6: asynchronous reset mid-word discards the partial word.
    task automatic test_reset_mid_word();
        send_byte(8'h11);
        send_byte(8'h22);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_async");
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset_mid_word_held");
        rst = 1'b0;
        @(negedge clk);
        push_exp(32'h01020304, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(i + 1));
            assertions++;
            if (word_cmd !== (i == 3)) begin
                failures++;
                $display("FAIL reset_mid_word_strobe%0d: got cmd=%b, expected %b", i, word_cmd, (i == 3));
            end
        end
    endtask

    // Error counter saturates at all-ones: one realign per 5-byte group.
    task automatic test_err_saturation();
        logic [7:0] bytes [5] = '{8'hAA, 8'h41, 8'h6F, 8'hDC, 8'h1E};
        int exp_err;
        apply_reset();
        for (int g = 1; g <= 260; g++) begin
            push_exp(32'hAA416FDC, 1'b0);
            push_exp(32'h416FDC1E, 1'b1);
            for (int i = 0; i < 5; i++) send_byte(bytes[i]);
            exp_err = (g > 255) ? 255 : g;
            if (g >= 250) begin
                assertions++;
                if (err_count !== 8'(exp_err)) begin
                    failures++;
                    $display("FAIL err_saturation_group%0d: got err=%0d, expected %0d", g, err_count, exp_err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_realign();
        test_aligned_resync();
        test_timeout();
        test_reset_mid_word();
        test_err_saturation();
        repeat (3) @(negedge clk);
        assertions++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d words outstanding, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
